// File: rtl/spi_top.sv
// spi_top - board-level SPI master demo (mode 0, MSB first, 8-bit frames).
//
// Pushing the start button shifts the switch byte out on the GPIO header
// and captures the byte returned on MISO. The LEDs show either the last
// received byte or a count of completed frames.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-low
//   leds        received byte, or frame count when xb_buttons[0] is high
//   buttons     [0] start, [1] clear, [3:2] not used by the logic
//   switches    byte to transmit
//   xb_buttons  [0] display select (1 = frame count), [2:1] not used
//   gpio        [21] SCLK, [22] MOSI, [23] MISO (input), [24] CS_n,
//               [35:25] left floating
module spi_top #(
  parameter int CLK_DIV     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] leds,
  input  logic [3:0] buttons,
  input  logic [7:0] switches,
  input  logic [2:0] xb_buttons,
  inout  wire [35:21] gpio
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] start_sync, clear_sync, disp_sync;
  logic start_prev, clear_prev;
  logic start_pulse, clear_pulse;

  logic [DIV_W-1:0] div_cnt;
  logic             div_done;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_shift, rx_shift;
  logic [7:0]       rx_reg, frame_cnt;
  logic             sclk, mosi, cs_n;
  logic             miso;

  // Unused board inputs are folded here so they are visibly accounted for.
  logic unused_inputs;
  assign unused_inputs = ^{buttons[3:2], xb_buttons[2:1]};

  assign gpio[21]    = sclk;
  assign gpio[22]    = mosi;
  assign gpio[23]    = 1'bz;
  assign gpio[24]    = cs_n;
  assign gpio[35:25] = 'z;
  assign miso        = gpio[23];

  // Button synchronizers plus the previous-value flops for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_sync <= '0;
      clear_sync <= '0;
      disp_sync  <= '0;
      start_prev <= 1'b0;
      clear_prev <= 1'b0;
    end else begin
      start_sync[0] <= buttons[0];
      clear_sync[0] <= buttons[1];
      disp_sync[0]  <= xb_buttons[0];
      for (int i = 1; i < SYNC_STAGES; i++) begin
        start_sync[i] <= start_sync[i-1];
        clear_sync[i] <= clear_sync[i-1];
        disp_sync[i]  <= disp_sync[i-1];
      end
      start_prev <= start_sync[SYNC_STAGES-1];
      clear_prev <= clear_sync[SYNC_STAGES-1];
    end
  end

  assign start_pulse = start_sync[SYNC_STAGES-1] & ~start_prev;
  assign clear_pulse = clear_sync[SYNC_STAGES-1] & ~clear_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    div_done   = (div_cnt == DIV_MAX);
    case (state)
      IDLE:  if (start_pulse) next_state = SETUP;
      SETUP: if (div_done) next_state = HIGH;
      HIGH:  if (div_done) next_state = LOW;
      LOW:   if (div_done) next_state = (bit_cnt == 3'd0) ? DONE : HIGH;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pin registers are computed from next_state so SCLK/CS_n change on the
  // same edge as the state they belong to, glitch-free and without lag.
  // Entry actions (MISO sample, MOSI shift) likewise key on the transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt   <= '0;
      bit_cnt   <= 3'd0;
      tx_shift  <= 8'h00;
      rx_shift  <= 8'h00;
      rx_reg    <= 8'h00;
      frame_cnt <= 8'h00;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cs_n      <= 1'b1;
      leds      <= 8'h00;
    end else begin
      if (next_state != state || state == IDLE || state == DONE) div_cnt <= '0;
      else                                                     div_cnt <= div_cnt + 1'b1;

      sclk <= (next_state == HIGH);
      cs_n <= !(next_state == SETUP || next_state == HIGH || next_state == LOW);

      if (state == IDLE && start_pulse) begin
        tx_shift <= switches;
        bit_cnt  <= 3'd7;
        mosi     <= switches[7];
      end

      if (state == HIGH && next_state == LOW) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
        mosi     <= tx_shift[6];
      end

      if (state == LOW && next_state == HIGH) bit_cnt <= bit_cnt - 3'd1;

      if (state != HIGH && next_state == HIGH) rx_shift <= {rx_shift[6:0], miso};

      if (next_state == DONE) mosi <= 1'b0;

      // Clear has priority over a coinciding frame completion.
      if (clear_pulse) begin
        rx_reg    <= 8'h00;
        frame_cnt <= 8'h00;
      end else if (state == DONE) begin
        rx_reg    <= rx_shift;
        frame_cnt <= frame_cnt + 8'd1;
      end

      leds <= disp_sync[SYNC_STAGES-1] ? frame_cnt : rx_reg;
    end
  end

endmodule

// File: tb/tb_spi_top.sv
// tb_spi_top - directed self-checking bench for spi_top (CLK_DIV=4,
// SYNC_STAGES=2). MISO is either looped back from MOSI or held at a level.
module tb_spi_top;

  logic        clk;
  logic        rst;
  logic [7:0]  leds;
  logic [3:0]  buttons;
  logic [7:0]  switches;
  logic [2:0]  xb_buttons;
  wire  [35:21] gpio;

  logic loopback;
  logic miso_hold;

  int checks = 0;
  int errors = 0;

  logic       mon_clr;
  int         rises;
  int         cs_low;
  logic [7:0] mosi_bits;
  logic       sclk_prev;

  logic sclk_w, mosi_w, cs_n_w;

  assign sclk_w   = gpio[21];
  assign mosi_w   = gpio[22];
  assign cs_n_w   = gpio[24];
  assign gpio[23] = loopback ? gpio[22] : miso_hold;

  spi_top #(.CLK_DIV(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .leds       (leds),
    .buttons    (buttons),
    .switches   (switches),
    .xb_buttons (xb_buttons),
    .gpio       (gpio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor: counts SCLK rising edges, records MOSI at each one, and
  // counts clk edges during which CS_n was low.
  always @(posedge clk) begin
    if (mon_clr) begin
      rises     = 0;
      cs_low    = 0;
      mosi_bits = 8'h00;
    end else begin
      if (cs_n_w == 1'b0) cs_low = cs_low + 1;
      if (sclk_w && !sclk_prev) begin
        rises     = rises + 1;
        mosi_bits = {mosi_bits[6:0], mosi_w};
      end
    end
    sclk_prev = sclk_w;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearMonitor();
    mon_clr = 1'b1;
    cycles(1);
    mon_clr = 1'b0;
  endtask

  // Load the switches and press start for a few cycles.
  task automatic applyStimulus(input logic [7:0] sw);
    switches   = sw;
    buttons[0] = 1'b1;
    cycles(4);
    buttons[0] = 1'b0;
  endtask

  task automatic pressClear();
    buttons[1] = 1'b1;
    cycles(4);
    buttons[1] = 1'b0;
    cycles(2);
  endtask

  task automatic waitCs(input logic level, input string tag);
    int n = 0;
    while (cs_n_w !== level && n < 1000) begin
      cycles(1);
      n++;
    end
    checkOutput(tag, {31'd0, cs_n_w}, {31'd0, level});
  endtask

  // Full frame: press start, wait for CS_n low then high, let leds settle.
  task automatic runFrame(input logic [7:0] sw, input string tag);
    clearMonitor();
    applyStimulus(sw);
    waitCs(1'b0, {tag, "_cs_fall"});
    waitCs(1'b1, {tag, "_cs_rise"});
    cycles(4);
  endtask

  initial begin
    rst        = 1'b0;
    buttons    = 4'h0;
    switches   = 8'h00;
    xb_buttons = 3'h0;
    loopback   = 1'b1;
    miso_hold  = 1'b0;
    mon_clr    = 1'b0;
    rises      = 0;
    cs_low     = 0;
    mosi_bits  = 8'h00;
    sclk_prev  = 1'b0;

    cycles(3);
    checkOutput("reset_cs_n", {31'd0, cs_n_w}, 32'd1);
    checkOutput("reset_sclk", {31'd0, sclk_w}, 32'd0);
    checkOutput("reset_mosi", {31'd0, mosi_w}, 32'd0);
    checkOutput("reset_leds", {24'd0, leds}, 32'h00);
    @(negedge clk);
    rst = 1'b1;
    cycles(3);

    // Loopback A5.
    runFrame(8'hA5, "lb_a5");
    checkOutput("lb_a5_rises", rises, 32'd8);
    checkOutput("lb_a5_mosi", {24'd0, mosi_bits}, 32'hA5);
    checkOutput("lb_a5_cs_low", cs_low, 32'd68);
    checkOutput("lb_a5_leds", {24'd0, leds}, 32'hA5);

    // Reset pulse mid-run.
    rst = 1'b0;
    #1;
    checkOutput("rst2_cs_n", {31'd0, cs_n_w}, 32'd1);
    checkOutput("rst2_sclk", {31'd0, sclk_w}, 32'd0);
    checkOutput("rst2_leds", {24'd0, leds}, 32'h00);
    @(negedge clk);
    rst = 1'b1;
    cycles(3);

    // MISO held high.
    loopback  = 1'b0;
    miso_hold = 1'b1;
    runFrame(8'h3C, "hi_3c");
    checkOutput("hi_3c_mosi", {24'd0, mosi_bits}, 32'h3C);
    checkOutput("hi_3c_leds", {24'd0, leds}, 32'hFF);
    xb_buttons[0] = 1'b1;
    cycles(5);
    checkOutput("hi_cnt1", {24'd0, leds}, 32'h01);
    runFrame(8'h3C, "hi_3c_b");
    checkOutput("hi_cnt2", {24'd0, leds}, 32'h02);

    // Start and switch change mid-frame are ignored.
    loopback = 1'b1;
    clearMonitor();
    applyStimulus(8'h5A);
    waitCs(1'b0, "mid_cs_fall");
    cycles(20);
    applyStimulus(8'hFF);
    waitCs(1'b1, "mid_cs_rise");
    cycles(4);
    checkOutput("mid_rises", rises, 32'd8);
    checkOutput("mid_mosi", {24'd0, mosi_bits}, 32'h5A);
    checkOutput("mid_cnt3", {24'd0, leds}, 32'h03);
    cycles(30);
    checkOutput("mid_no_requeue", {31'd0, cs_n_w}, 32'd1);
    checkOutput("mid_rises_after", rises, 32'd8);
    xb_buttons[0] = 1'b0;
    cycles(5);
    checkOutput("mid_leds", {24'd0, leds}, 32'h5A);

    // Reset after the third SCLK edge.
    clearMonitor();
    applyStimulus(8'hC3);
    begin
      int n = 0;
      while (rises < 3 && n < 1000) begin
        cycles(1);
        n++;
      end
    end
    checkOutput("abort_rises", rises, 32'd3);
    rst = 1'b0;
    #1;
    checkOutput("abort_cs_n", {31'd0, cs_n_w}, 32'd1);
    checkOutput("abort_sclk", {31'd0, sclk_w}, 32'd0);
    checkOutput("abort_leds", {24'd0, leds}, 32'h00);
    @(negedge clk);
    rst = 1'b1;
    cycles(5);
    checkOutput("abort_rx_reg", {24'd0, leds}, 32'h00);
    runFrame(8'h96, "post_abort");
    checkOutput("post_abort_rises", rises, 32'd8);
    checkOutput("post_abort_leds", {24'd0, leds}, 32'h96);
    xb_buttons[0] = 1'b1;
    cycles(5);
    checkOutput("post_abort_cnt1", {24'd0, leds}, 32'h01);

    // Clear after two frames.
    runFrame(8'h81, "pre_clear");
    checkOutput("pre_clear_cnt2", {24'd0, leds}, 32'h02);
    pressClear();
    cycles(2);
    checkOutput("clear_cnt", {24'd0, leds}, 32'h00);
    xb_buttons[0] = 1'b0;
    cycles(5);
    checkOutput("clear_rx", {24'd0, leds}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_top.md
Name: spi_top

Overview:
- Board-level top for the SPI demo on the Spartan-3 board: one SPI master (mode 0, MSB first, 8-bit frames) driven from on-board switches and buttons.
- Pushing the start button shifts the switch byte out over the GPIO header and captures the returned byte.
- The received byte, or a frame counter, is shown on the LEDs.
- Contains the button synchronizers, edge detector, clock divider, shift FSM and display mux.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period, minimum 1.
- SYNC_STAGES, 2: flip-flop stages in each button synchronizer.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- leds  output  8  display: received byte, or frame count.
- buttons  input  4  [0] start, [1] clear, [2] unused, [3] unused by logic (wired to reset on the board).
- switches  input  8  transmit byte.
- xb_buttons  input  3  [0] display select (1 = frame count), [2:1] unused.
- gpio  inout  15  bits [35:21]:
  - gpio[21] SCLK output.
  - gpio[22] MOSI output.
  - gpio[23] MISO input.
  - gpio[24] CS_n output.
  - gpio[35:25] high-Z.

Behaviour:
- Reset (rst=0, asynchronous) values:
  - SCLK=0, MOSI=0, CS_n=1.
  - rx_reg=0x00, frame_cnt=0x00, leds=0x00.
  - FSM=IDLE, synchronizers cleared.
- buttons[0], buttons[1] and xb_buttons[0] each pass through a SYNC_STAGES flip-flop synchronizer.
- start_pulse: one clk cycle on the synchronized 0->1 edge of buttons[0]. clear_pulse is formed the same way from buttons[1].
- FSM states: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE:
  - CS_n=1, SCLK=0.
  - On start_pulse: tx_shift <= switches, sampled at that cycle; bit_cnt <= 7; go to SETUP.
- SETUP:
  - CS_n=0; MOSI=tx_shift[7].
  - Wait CLK_DIV cycles, then go to HIGH.
- HIGH:
  - SCLK=1. On entry, sample gpio[23] into rx_shift: rx_shift <= {rx_shift[6:0], miso}.
  - Hold CLK_DIV cycles, then go to LOW.
- LOW:
  - SCLK=0. On entry, shift tx_shift left and drive the next bit on MOSI.
  - After CLK_DIV cycles: if bit_cnt==0 go to DONE; otherwise bit_cnt-1 and go to HIGH.
- DONE (one cycle):
  - CS_n=1; rx_reg <= rx_shift; frame_cnt <= frame_cnt+1, wrapping 0xFF->0x00.
  - MOSI=0; go to IDLE.
- Frame timing:
  - Exactly 8 SCLK rising edges per frame.
  - CS_n is low for 17*CLK_DIV cycles.
  - Frame is CS_n falling to rx_reg valid in 17*CLK_DIV+1 cycles.
- start_pulse outside IDLE is ignored; it is not queued.
- Switch changes during a frame do not affect that frame.
- clear_pulse: rx_reg <= 0 and frame_cnt <= 0 in any state.
  - An in-flight frame still completes.
  - If clear and DONE coincide, clear wins for frame_cnt and rx_reg.
- leds = xb_buttons[0] synchronized ? frame_cnt : rx_reg. Registered, 1 cycle latency.
- Reset mid-frame aborts immediately: CS_n=1, SCLK=0, and no partial data reaches rx_reg.
- CS_n, SCLK and MOSI are driven from registers, so there is no combinational glitching.
- gpio[35:25] and gpio[23] are never driven.

Test Plan:
- Reset check: pulse rst low mid-run. Required: CS_n=1, SCLK=0, leds=0x00, gpio[35:25]=Z.
- Loopback, gpio[23] tied to gpio[22], switches=0xA5, press buttons[0]:
  - Exactly 8 SCLK rising edges; MOSI bits 1,0,1,0,0,1,0,1.
  - leds=0xA5 after CS_n rises.
  - With CLK_DIV=4, CS_n is low for 68 cycles.
- MISO held at 1, switches=0x3C:
  - leds=0xFF; with xb_buttons[0]=1, leds=0x01.
  - A second frame gives leds=0x02.
- Start pressed again mid-frame:
  - Ignored: 8 rising edges only; frame_cnt increments by one.
  - Switches changed mid-frame do not alter the transmitted MOSI bits.
- rst asserted after the 3rd SCLK edge:
  - Outputs go to reset values immediately; rx_reg=0x00.
  - A new start then completes a normal frame.
- buttons[1] press after two frames: leds=0x00 in both display modes.
